// File: rtl/spi_slave_gen2.sv
// SPI slave: 2-bit command + DATA_W payload frames. Write frames are reported on
// rx_data; a read-address frame arms a following read-data frame, which returns tx_data on MISO.
module spi_slave_gen2 #(
   parameter int DATA_W    = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              frame_err
);

   localparam int RX_W  = DATA_W + 2;
   localparam int CNT_W = $clog2(RX_W + 1);
   localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_W - 1);
   localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W);

   typedef enum logic [2:0] {
      IDLE, CHK_CMD, WRITE, READ_ADDR, READ_DATA, READ_WAIT, SEND, WAIT_SS
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [RX_W-2:0]   rx_shift, rx_shift_nxt;
   logic [DATA_W-1:0] tx_shift, tx_shift_nxt;
   logic              addr_rcvd, addr_rcvd_nxt;
   logic              miso_nxt, rx_valid_nxt, frame_err_nxt;
   logic [RX_W-1:0]   rx_data_nxt;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         addr_rcvd <= 1'b0;
         MISO      <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rx_shift  <= rx_shift_nxt;
         tx_shift  <= tx_shift_nxt;
         addr_rcvd <= addr_rcvd_nxt;
         MISO      <= miso_nxt;
         rx_data   <= rx_data_nxt;
         rx_valid  <= rx_valid_nxt;
         frame_err <= frame_err_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first, so no path can infer a latch.
      state_nxt     = state;
      cnt_nxt       = cnt;
      rx_shift_nxt  = rx_shift;
      tx_shift_nxt  = tx_shift;
      addr_rcvd_nxt = addr_rcvd;
      rx_data_nxt   = rx_data;
      rx_valid_nxt  = 1'b0;
      frame_err_nxt = 1'b0;
      miso_nxt      = 1'b0;

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!SS_n) state_nxt = CHK_CMD;
         end

         CHK_CMD: begin
            if (SS_n) begin
               state_nxt     = IDLE;
               frame_err_nxt = 1'b1;
            end else begin
               rx_shift_nxt = {{(RX_W-2){1'b0}}, MOSI};
               cnt_nxt      = CNT_W'(1);
               if (!MOSI)          state_nxt = WRITE;
               else if (!addr_rcvd) state_nxt = READ_ADDR;
               else                state_nxt = READ_DATA;
            end
         end

         WRITE, READ_ADDR, READ_DATA: begin
            if (SS_n) begin
               state_nxt     = IDLE;
               frame_err_nxt = 1'b1;
            end else begin
               rx_shift_nxt = {rx_shift[RX_W-3:0], MOSI};
               cnt_nxt      = cnt + CNT_W'(1);
               if (cnt == RX_LAST) begin
                  rx_data_nxt  = {rx_shift, MOSI};
                  rx_valid_nxt = 1'b1;
                  if (state == READ_DATA) begin
                     state_nxt = READ_WAIT;
                  end else begin
                     state_nxt = WAIT_SS;
                     if (state == READ_ADDR) addr_rcvd_nxt = 1'b1;
                  end
               end
            end
         end

         READ_WAIT: begin
            if (SS_n) begin
               state_nxt     = IDLE;
               frame_err_nxt = 1'b1;
            end else if (tx_valid) begin
               state_nxt = SEND;
               cnt_nxt   = CNT_W'(1);
               if (LSB_FIRST) begin
                  miso_nxt     = tx_data[0];
                  tx_shift_nxt = tx_data >> 1;
               end else begin
                  miso_nxt     = tx_data[DATA_W-1];
                  tx_shift_nxt = tx_data << 1;
               end
            end
         end

         SEND: begin
            if (SS_n) begin
               state_nxt     = IDLE;
               frame_err_nxt = 1'b1;
            end else if (cnt == TX_LAST) begin
               // cnt counts bits already on the wire; once all are out, release MISO.
               state_nxt     = WAIT_SS;
               addr_rcvd_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
               if (LSB_FIRST) begin
                  miso_nxt     = tx_shift[0];
                  tx_shift_nxt = tx_shift >> 1;
               end else begin
                  miso_nxt     = tx_shift[DATA_W-1];
                  tx_shift_nxt = tx_shift << 1;
               end
            end
         end

         WAIT_SS: begin
            if (SS_n) state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule
